// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//
// Load/store bus between the core's memory stage (master) and the data
// memory responder (slave).
//
// Request handshake: the master holds req_valid and every req_* field stable
// until a rising clock edge where req_valid and req_ready are both 1. That
// edge transfers the request. req_ready is 1 only when the responder is idle.
// The response is a one-cycle resp_valid pulse with no backpressure.
// resp_rdata and resp_err are meaningful while resp_valid is 1 and keep their
// values afterwards.
//
// Signals:
//   req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata
//     request from master
//   req_ready                        responder idle and able to accept
//   resp_valid, resp_rdata, resp_err response to master
//   dbg_state                        responder FSM state, for observation only
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  dbg_state;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, dbg_state
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, dbg_state
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the core's load/store interface. The responder accepts
// one request at a time and performs a byte, halfword or word access on a
// word-organised little-endian array. It then returns a one-cycle response.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high. Aborts any transaction in flight.
//   bus    dmem_responder_if.slave (request/response bus, FSM debug state)
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words. Byte addresses 0 .. 4*DEPTH_WORDS-1.
//   LATENCY      wait cycles between acceptance and the array access (0..15).
//
// Build option:
//   DMEM_MISALIGN_SPLIT_EN  when defined, accesses that cross a word boundary
//   are split over two array cycles (ACC1, ACC2). When undefined, such
//   accesses are answered with resp_err=1 and perform no write.
//
// Timing: a request accepted at edge k gives resp_valid in the cycle after
// edge k+2+LATENCY. A split access adds one cycle.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 0
) (
    input  logic clock,
    input  logic reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACC1 = 3'd2,
        ST_ACC2 = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbytes_q, rbytes_d;   // addressed bytes, right-aligned
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [2:0]    nbytes;
    logic [32:0]   last_addr;
    logic          crosses;
    logic          acc_err;
    logic [AW-1:0] idx0, idx1;
    logic [31:0]   cur_word;
    logic [2:0]    off;
    logic          in_acc;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic [31:0]   ext;

    always_comb begin
        // Defaults for the access decode.
        nbytes    = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
        // A 33-bit sum catches addresses that wrap past 0xFFFFFFFF.
        last_addr = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
        crosses   = ((size_q == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
        acc_err   = (size_q == 2'b11) || (last_addr >= LIMIT) || (crosses && !SPLIT_EN);
        idx0      = addr_q[AW+1:2];
        idx1      = idx0 + 1'b1;
        in_acc    = (state_q == ST_ACC2) || ((state_q == ST_ACC1) && !acc_err);
        cur_word  = (state_q == ST_ACC2) ? mem_q[idx1] : mem_q[idx0];
        off       = 3'd0;

        rbytes_d  = rbytes_q;
        wr_data   = 32'd0;
        wr_be     = 4'd0;
        // Byte i of the access lives at lane (addr[1:0]+i) mod 4. Its word is
        // the first one when the sum stays below 4, else the following one.
        // Each access state handles only the bytes that fall in its word.
        for (int i = 0; i < 4; i++) begin
            off = {1'b0, addr_q[1:0]} + 3'(i);
            if (in_acc && (3'(i) < nbytes) && (off[2] == (state_q == ST_ACC2))) begin
                rbytes_d[8*i +: 8]                 = cur_word[{off[1:0], 3'b000} +: 8];
                wr_be[off[1:0]]                    = 1'b1;
                wr_data[{off[1:0], 3'b000} +: 8]   = wdata_q[8*i +: 8];
            end
        end
        wr_en  = in_acc && write_q;
        wr_idx = (state_q == ST_ACC2) ? idx1 : idx0;

        case (size_q)
            2'b00:   ext = unsigned_q ? {24'd0, rbytes_q[7:0]}
                                      : {{24{rbytes_q[7]}}, rbytes_q[7:0]};
            2'b01:   ext = unsigned_q ? {16'd0, rbytes_q[15:0]}
                                      : {{16{rbytes_q[15]}}, rbytes_q[15:0]};
            default: ext = rbytes_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d    = bus.req_write;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    wait_cnt_d = 4'd0;
                    state_d    = (LATENCY > 0) ? ST_WAIT : ST_ACC1;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'(LATENCY - 1)) begin
                    state_d = ST_ACC1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_ACC1: begin
                err_d = acc_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
                state_d = (crosses && !acc_err) ? ST_ACC2 : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                // The response registers load on the edge that leaves RESP,
                // so the pulse appears in the first cycle back in IDLE.
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
                resp_rdata_d = (err_q || write_q) ? 32'd0 : ext;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rbytes_q     <= 32'd0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbytes_q     <= rbytes_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array contents are not reset. During reset the FSM sits in IDLE, so
    // wr_en stays low and a pending store is dropped.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the processor's load/store interface.
- Accepts one request at a time over a valid/ready handshake, performs byte, halfword or word reads and writes on an internal word-organised little-endian array, and returns a single-cycle response.
- Supports configurable wait states and optional split handling of accesses that cross a word boundary.
- Serves lh/sh (plus lb/lw variants) issued by the core's memory stage.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; valid byte addresses 0 .. 4*DEPTH_WORDS-1.
LATENCY, 0, extra wait cycles inserted between request acceptance and the array access (0..15).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned (sh uses bits 15:0).
resp_valid  output  1  one-cycle pulse, response present.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  valid with resp_valid: illegal size, out of range, or unsupported misalignment.

Behaviour:
- Reset (asynchronous): state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; wait counter=0.
- Array contents are not reset.
- Reset asserted mid-transaction aborts it with no response. A write not yet performed is discarded.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, capture write, size, unsigned, addr and wdata. Go to WAIT if LATENCY>0, else ACC1.
  - WAIT: count LATENCY cycles, then go to ACC1.
  - ACC1: access the word at addr[31:2] using byte lanes from addr[1:0]. If the access crosses a word boundary and split is enabled, go to ACC2; otherwise go to RESP.
  - ACC2: access the next word (addr[31:2]+1) for the remaining bytes, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- req_ready is 0 in every state except IDLE. There is no response backpressure.
- Timing: request accepted at edge k, resp_valid high in the cycle after edge k+2+LATENCY. A split access adds 1 cycle.
- Store byte lanes: only addressed bytes are written. Byte writes wdata[7:0], halfword writes wdata[15:0] (low byte at lower address), word writes wdata[31:0].
- Load: assemble the addressed bytes, then sign- or zero-extend per req_unsigned. Word loads ignore req_unsigned.
- Crossing condition: halfword with addr[1:0]=11, or word with addr[1:0]!=00.
- Error checks happen in ACC1 before any write:
  - Error if req_size=11.
  - Error if the last byte address is ≥ 4*DEPTH_WORDS (this includes the second word of a split).
  - Error if the access crosses a word boundary with split disabled.
  - On any error: no array write, resp_rdata=0, resp_err=1.
- Highest valid halfword address is 4*DEPTH_WORDS-2. An address wrapping past 0xFFFFFFFF is out of range.
- resp_rdata and resp_err hold their last values when resp_valid=0.

Optional Feature:
DMEM_MISALIGN_SPLIT_EN:
- Defined: word-crossing accesses use ACC2; a split store writes both words; the response arrives one cycle later.
- Undefined: ACC2 is absent; crossing accesses return resp_err=1, perform no write, and resp_rdata=0.

Test Plan:
1. LATENCY=0: sw 0x11223344 @0x10, then sh 0x0000BEEF @0x12, then lw @0x10 -> resp_rdata=0xBEEF3344, resp_err=0.
2. sh 0xABCD @0x20; lh @0x20 -> 0xFFFFABCD; lhu @0x20 -> 0x0000ABCD; lb @0x21 -> 0xFFFFFFAB.
3. LATENCY=2: request accepted at edge k -> req_ready=0 until RESP ends, resp_valid high only in the cycle after edge k+4; a req_valid held during busy cycles is not accepted.
4. sw 0x80000000 @0x10, sw 0x000000FF @0x14, lh @0x13:
   - with DMEM_MISALIGN_SPLIT_EN -> 0xFFFFFF80 after one extra cycle.
   - without -> resp_err=1, rdata=0.
5. DEPTH_WORDS=256: sh @0x3FE succeeds. lh @0x400 -> resp_err=1. sh @0x400 -> no write and resp_err=1. req_size=11 -> resp_err=1.
6. Assert reset in WAIT of an sh 0x1234 @0x30 -> outputs return to reset values immediately, no resp_valid; after release, lhu @0x30 returns the prior contents (not 0x1234).
